// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the DMEM responder slice.
package dmem_responder_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int DMEM_DEPTH_WORDS = 256;
    localparam int DMEM_LATENCY     = 2;
    localparam int DMEM_CNT_WIDTH   = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// DMEM request/response bundle between the execution stage (master) and the memory (slave).
interface dmem_responder_if #(
    parameter int AW = dmem_responder_pkg::ADDR_WIDTH,
    parameter int DW = dmem_responder_pkg::DATA_WIDTH
);
    logic          dmem_req_i;
    logic [AW-1:0] dmem_addr_i;
    logic          dmem_we_i;
    logic [DW-1:0] dmem_wdata_i;
    logic [DW-1:0] dmem_rdata_o;
    logic          dmem_ack_o;

    modport master (
        output dmem_req_i, dmem_addr_i, dmem_we_i, dmem_wdata_i,
        input  dmem_rdata_o, dmem_ack_o
    );

    modport slave (
        input  dmem_req_i, dmem_addr_i, dmem_we_i, dmem_wdata_i,
        output dmem_rdata_o, dmem_ack_o
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Word storage with one synchronous write port and one registered read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  rd_zero_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage write; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_r[idx_i] <= wdata_i;
        end
    end

    // Read register: loads on every commit, zero for stores and out-of-range loads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_r <= '0;
        end else if (rd_en_i) begin
            rdata_r <= rd_zero_i ? '0 : mem_r[idx_i];
        end
    end

    assign rdata_o = rdata_r;
endmodule

// File: rtl/dmem_responder.sv
// DMEM slave: latches one request, waits LATENCY cycles, commits and pulses ack for one cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int DEPTH_WORDS    = DMEM_DEPTH_WORDS,
    parameter int LATENCY        = DMEM_LATENCY
) (
    input  logic              clk_i,
    input  logic              arst_i,
    dmem_responder_if.slave   dmem
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = DMEM_CNT_WIDTH;
    localparam int WA_W  = MEM_ADDR_WIDTH - 2;

    logic                      rst_meta_r;
    logic                      rst_r;
    dmem_state_t               state_r;
    dmem_state_t               state_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_s;
    logic                      ack_r;
    logic                      ack_s;
    logic                      latch_s;
    logic                      commit_s;
    logic [WA_W-1:0]           waddr_r;
    logic                      we_r;
    logic [MEM_DATA_WIDTH-1:0] wdata_r;
    logic                      in_range_s;
    logic [IDX_W-1:0]          idx_s;
    logic [MEM_DATA_WIDTH-1:0] rdata_s;
    logic                      unused_addr_lsb_s;

    // Reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rst_meta_r <= 1'b1;
            rst_r      <= 1'b1;
        end else begin
            rst_meta_r <= 1'b0;
            rst_r      <= rst_meta_r;
        end
    end

    // FSM state, wait counter and ack flop
    always_ff @(posedge clk_i or posedge rst_r) begin
        if (rst_r) begin
            state_r <= DMEM_IDLE;
            cnt_r   <= '0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= ack_s;
        end
    end

    // Next-state logic; inputs matter only in IDLE and RESP
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ack_s    = 1'b0;
        latch_s  = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            DMEM_IDLE, DMEM_RESP: begin
                if (dmem.dmem_req_i) begin
                    latch_s = 1'b1;
                    cnt_s   = CNT_W'(LATENCY);
                    state_s = DMEM_WAIT;
                end else begin
                    state_s = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (cnt_r == '0) begin
                    commit_s = 1'b1;
                    ack_s    = 1'b1;
                    state_s  = DMEM_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = DMEM_IDLE;
            end
        endcase
    end

    // Request latch, loaded only on the sampling edge
    always_ff @(posedge clk_i or posedge rst_r) begin
        if (rst_r) begin
            waddr_r <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
        end else if (latch_s) begin
            waddr_r <= dmem.dmem_addr_i[MEM_ADDR_WIDTH-1:2];
            we_r    <= dmem.dmem_we_i;
            wdata_r <= dmem.dmem_wdata_i;
        end
    end

    // Any set bit above the index field means the access misses the array entirely
    assign in_range_s        = ((waddr_r >> IDX_W) == '0);
    assign idx_s             = waddr_r[IDX_W-1:0];
    assign unused_addr_lsb_s = ^dmem.dmem_addr_i[1:0];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (MEM_DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_r),
        .wr_en_i   (commit_s & we_r & in_range_s),
        .rd_en_i   (commit_s),
        .rd_zero_i (we_r | ~in_range_s),
        .idx_i     (idx_s),
        .wdata_i   (wdata_r),
        .rdata_o   (rdata_s)
    );

    assign dmem.dmem_rdata_o = rdata_s;
    assign dmem.dmem_ack_o   = ack_r;
endmodule
